mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sits in the M stage directly downstream of the byte-enable generator. Consumes its 4-bit byte enable plus address, store data and load type.
- Runs one variable-latency memory transaction over a req/ack bus and stalls the pipeline until the transaction completes.
- Store side: places store data on the correct byte lanes.
- Load side: extracts and extends read data (lb/lbu/lh/lhu/lw) for the W-stage register.

Parameters:
- TIMEOUT_CYCLES, 16, maximum REQ-state cycles before abort; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  M-stage instruction is a memory op
- req_we  in  1  1 = store, 0 = load
- byteen  in  4  byte enable from the upstream byte-enable generator (stores)
- addr  in  32  effective address
- wdata  in  32  rt value, unaligned (data in low bits)
- load_type  in  3  0 none, 1 lw, 2 lbu, 3 lb, 4 lhu, 5 lh
- stall  out  1  freeze F/D/E/M
- rdata_out  out  32  extended load result
- rdata_valid  out  1  one-cycle pulse, load result valid
- bus_err  out  1  one-cycle pulse on timeout
- bus_req  out  1  registered bus request
- bus_we  out  1  registered write flag
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_byteen  out  4  byteen for stores, 4'b0000 for loads
- bus_wdata  out  32  lane-aligned store data
- bus_ack  in  1  transaction done, sampled only in REQ
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset value of every output and internal register is 0. Reset mid-transaction drops bus_req immediately and returns the FSM to IDLE; the pending access is discarded.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - A request is "valid" when req_valid=1 and either (req_we=1 and byteen≠0) or (req_we=0 and load_type≠0).
  - On a valid request: stall=1 combinationally in the same cycle; latch addr, byteen, load_type and aligned wdata; go to REQ.
  - A store with byteen=0 or a load with load_type=0 is ignored: no stall, no bus activity.
- REQ:
  - bus_req=1 and stall=1. Bus outputs are held stable from registers until ack.
  - If bus_ack=1: latch bus_rdata and go to DONE.
  - Otherwise the timeout counter increments each REQ cycle. When it reaches TIMEOUT_CYCLES (if nonzero): drop bus_req, pulse bus_err, go to DONE with rdata_out=0.
- DONE:
  - stall=0 and bus_req=0.
  - rdata_valid=1 for loads that received an ack.
  - Unconditionally return to IDLE. A request seen in DONE is the instruction that is completing, so it is not re-accepted.
  - The next instruction is evaluated in the following IDLE cycle.
- Minimum latency (ack in the first REQ cycle): stall high for 2 cycles, result in cycle 3.
- Store alignment: bus_wdata = wdata << (8*addr[1:0]); lanes outside byteen are don't-care and driven as shifted data.
- Load extraction:
  - Byte: rdata >> (8*addr[1:0]), then low 8 bits, sign- or zero-extended.
  - Halfword: selected by addr[1]; lw passes the word through.
- A misaligned lw/lh with the feature disabled is truncated: addr[1:0] is used as given for byte select, and addr[0] is ignored for halfwords.
- rdata_out holds its last value until the next load's DONE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - In IDLE, a misaligned request (lw/sw with addr[1:0]≠0; lh/lhu/sh with addr[0]≠0) is not issued to the bus.
  - An extra output align_exc (1 bit) pulses for one cycle while stall stays low; the FSM stays in IDLE.
  - Store misalignment is derived from byteen: 4'b1111 means word, 4'b0011/4'b1100 means halfword.
- When undefined: there is no align_exc port and misaligned requests proceed with the truncation described above.

Decomposition:
- Shared package mem_pkg holds:
  - load_type encodings (LT_NONE, LT_LW, LT_LBU, LT_LB, LT_LHU, LT_LH)
  - FSM state encodings (S_IDLE, S_REQ, S_DONE)
  - byteen constants (BE_WORD, BE_HALF_LO, BE_HALF_HI)
- One natural combinational sub-module: load_ext. Inputs are the word, addr[1:0] and load_type; output is the extended 32-bit result. It is reusable by the W stage.

Test Plan:
- Store word, zero-wait: addr=0x100, byteen=1111, wdata=0xDEADBEEF, ack in the first REQ cycle -> bus_addr=0x100, bus_byteen=1111, bus_wdata=0xDEADBEEF, stall high exactly 2 cycles.
- Store byte: addr=0x203, byteen=1000, wdata=0x000000A5 -> bus_wdata[31:24]=0xA5, bus_addr=0x200, bus_we=1.
- Load lb and lbu: addr=0x302, bus_rdata=0x12F45678, ack after 3 cycles -> lb gives rdata_out=0xFFFFFFF4 and lbu gives 0x000000F4; rdata_valid pulses once; stall high 4 cycles.
- Load lh: addr=0x402, bus_rdata=0x8001ABCD -> rdata_out=0xFFFF8001.
- Timeout with TIMEOUT_CYCLES=16 and no ack -> bus_req drops after 16 REQ cycles, bus_err pulses once, stall releases the next cycle, rdata_valid stays 0.
- Reset asserted in the 2nd REQ cycle -> bus_req and stall go to 0 immediately; after release a new sw completes normally. With MEM_ALIGN_CHECK_EN defined: lw at 0x101 -> align_exc pulses, bus_req never asserts.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the M-stage memory access controller and its load extender.
// MEM_ALIGN_CHECK_EN enables the misalignment check helper's use in the controller.
package mem_pkg;

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LW   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LB   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LH   = 3'd5
    } load_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // Stores infer their width from the byte enable, loads from load_type.
    function automatic logic is_misaligned(input logic we, input logic [3:0] be,
                                           input logic [2:0] lt, input logic [1:0] a);
        if (we)
            return ((be == BE_WORD) && (a != 2'b00)) ||
                   (((be == BE_HALF_LO) || (be == BE_HALF_HI)) && a[0]);
        else
            return ((lt == LT_LW) && (a != 2'b00)) ||
                   (((lt == LT_LH) || (lt == LT_LHU)) && a[0]);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and bus-side signals of the memory access controller.
// MEM_ALIGN_CHECK_EN adds the align_exc output.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  byteen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  load_type;
    logic        stall;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_exc;
`endif

    modport slave (
`ifdef MEM_ALIGN_CHECK_EN
        output align_exc,
`endif
        input  req_valid, req_we, byteen, addr, wdata, load_type, bus_ack, bus_rdata,
        output stall, rdata_out, rdata_valid, bus_err, bus_req, bus_we, bus_addr,
               bus_byteen, bus_wdata
    );

    modport master (
`ifdef MEM_ALIGN_CHECK_EN
        input  align_exc,
`endif
        output req_valid, req_we, byteen, addr, wdata, load_type, bus_ack, bus_rdata,
        input  stall, rdata_out, rdata_valid, bus_err, bus_req, bus_we, bus_addr,
               bus_byteen, bus_wdata
    );
endinterface

// File: rtl/mem_access_ctrl_load_ext.sv
// Load extractor: selects byte/halfword from a read word and sign/zero extends it.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_load_type,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword select ignores addr[0], so a misaligned lh truncates.
    assign w_byte = i_word[{i_addr, 3'b000} +: 8];
    assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = '0;
        case (load_t'(i_load_type))
            LT_LW:   o_data = i_word;
            LT_LBU:  o_data = {24'b0, w_byte};
            LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LT_LHU:  o_data = {16'b0, w_half};
            LT_LH:   o_data = {{16{w_half[15]}}, w_half};
            default: o_data = '0;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage memory access controller: one req/ack bus transaction per op, stalls until done.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses with an align_exc pulse.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    mem_access_ctrl_if.slave mif
);
    state_t      r_state, w_next;
    logic        w_valid_req, w_misalign, w_accept, w_stall, w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic        r_req, r_we, r_rvalid, r_err;
    logic [31:0] r_addr, r_wdata, r_rdata, w_ext;
    logic [3:0]  r_byteen;
    logic [2:0]  r_lt;

    assign w_valid_req = mif.req_valid &&
                         (mif.req_we ? (mif.byteen != 4'b0000) : (mif.load_type != LT_NONE));

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign    = is_misaligned(mif.req_we, mif.byteen, mif.load_type, mif.addr[1:0]);
    assign mif.align_exc = (r_state == S_IDLE) && w_valid_req && w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_timeout = (TIMEOUT_CYCLES != 0) && !mif.bus_ack &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            S_IDLE: if (w_valid_req && !w_misalign) begin
                w_accept = 1'b1;
                w_stall  = 1'b1;
                w_next   = S_REQ;
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (mif.bus_ack || w_timeout) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    load_ext u_load_ext (
        .i_word      (mif.bus_rdata),
        .i_addr      (r_addr[1:0]),
        .i_load_type (r_lt),
        .o_data      (w_ext)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_byteen <= '0;
            r_wdata  <= '0;
            r_lt     <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (w_accept) begin
                r_req    <= 1'b1;
                r_we     <= mif.req_we;
                r_addr   <= mif.addr;
                r_byteen <= mif.req_we ? mif.byteen : 4'b0000;
                r_wdata  <= mif.wdata << {mif.addr[1:0], 3'b000};
                r_lt     <= mif.req_we ? LT_NONE : mif.load_type;
                r_cnt    <= '0;
            end
            if (r_state == S_REQ) begin
                if (mif.bus_ack) begin
                    r_req <= 1'b0;
                    if (!r_we) begin
                        r_rdata  <= w_ext;
                        r_rvalid <= 1'b1;
                    end
                end else if (w_timeout) begin
                    r_req <= 1'b0;
                    r_err <= 1'b1;
                    if (!r_we) r_rdata <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign mif.stall       = w_stall;
    assign mif.rdata_out   = r_rdata;
    assign mif.rdata_valid = r_rvalid;
    assign mif.bus_err     = r_err;
    assign mif.bus_req     = r_req;
    assign mif.bus_we      = r_we;
    assign mif.bus_addr    = {r_addr[31:2], 2'b00};
    assign mif.bus_byteen  = r_byteen;
    assign mif.bus_wdata   = r_wdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, ignored ops, timeout, mid-transaction reset.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if mif();

    mem_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .mif     (mif.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          stall_cyc, req_cyc, vld_cnt, err_cnt;
    logic [31:0] cap_addr, cap_wdata, cap_rdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    // Holds req_valid until the DONE cycle, as the stalled pipeline would.
    // ack_at = REQ cycle in which bus_ack is driven (0 = never).
    task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] lt, input int ack_at,
                           input logic [31:0] rd);
        bit done = 0;
        stall_cyc = 0; req_cyc = 0; vld_cnt = 0; err_cnt = 0;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_we = we; mif.byteen = be; mif.addr = a;
        mif.wdata = wd; mif.load_type = lt; mif.bus_rdata = rd; mif.bus_ack = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mif.rdata_valid) vld_cnt++;
            if (mif.bus_err) err_cnt++;
            if (mif.bus_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    cap_addr = mif.bus_addr; cap_wdata = mif.bus_wdata;
                    cap_be = mif.bus_byteen; cap_we = mif.bus_we;
                end
            end
            mif.bus_ack = mif.bus_req && (req_cyc == ack_at);
            if (mif.stall) stall_cyc++;
            else begin
                cap_rdata = mif.rdata_out;
                done = 1;
                break;
            end
        end
        if (!done) chk("txn_bound", 32'd0, 32'd1);
        @(posedge clk); #1;
        mif.req_valid = 1'b0; mif.bus_ack = 1'b0;
        @(negedge clk);
        if (mif.rdata_valid) vld_cnt++;
        if (mif.bus_err) err_cnt++;
    endtask

    initial begin
        mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.byteen = '0; mif.addr = '0;
        mif.wdata = '0; mif.load_type = '0; mif.bus_ack = 1'b0; mif.bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, mif.stall}, 32'd0);
        chk("rst_bus_req", {31'b0, mif.bus_req}, 32'd0);
        chk("rst_rdata", mif.rdata_out, 32'd0);
        chk("rst_bus_addr", mif.bus_addr, 32'd0);
        chk("rst_bus_wdata", mif.bus_wdata, 32'd0);
        rst = 1'b0;

        run_txn(1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, LT_NONE, 1, 32'h0);
        chk("sw_addr", cap_addr, 32'h100);
        chk("sw_be", {28'b0, cap_be}, 32'hF);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk("sw_we", {31'b0, cap_we}, 32'd1);
        chk("sw_stall", stall_cyc, 32'd2);
        chk("sw_vld", vld_cnt, 32'd0);

        run_txn(1'b1, 4'b1000, 32'h203, 32'h000000A5, LT_NONE, 1, 32'h0);
        chk("sb_addr", cap_addr, 32'h200);
        chk("sb_wdata", cap_wdata, 32'hA5000000);
        chk("sb_be", {28'b0, cap_be}, 32'h8);
        chk("sb_we", {31'b0, cap_we}, 32'd1);

        run_txn(1'b0, 4'b0000, 32'h302, 32'h0, LT_LB, 3, 32'h12F45678);
        chk("lb_rdata", cap_rdata, 32'hFFFFFFF4);
        chk("lb_vld", vld_cnt, 32'd1);
        chk("lb_stall", stall_cyc, 32'd4);
        chk("lb_addr", cap_addr, 32'h300);
        chk("lb_be", {28'b0, cap_be}, 32'h0);
        chk("lb_we", {31'b0, cap_we}, 32'd0);

        run_txn(1'b0, 4'b0000, 32'h302, 32'h0, LT_LBU, 3, 32'h12F45678);
        chk("lbu_rdata", cap_rdata, 32'h000000F4);
        chk("lbu_vld", vld_cnt, 32'd1);

        run_txn(1'b0, 4'b0000, 32'h402, 32'h0, LT_LH, 1, 32'h8001ABCD);
        chk("lh_rdata", cap_rdata, 32'hFFFF8001);
        run_txn(1'b0, 4'b0000, 32'h400, 32'h0, LT_LHU, 2, 32'h8001ABCD);
        chk("lhu_rdata", cap_rdata, 32'h0000ABCD);
        chk("lhu_stall", stall_cyc, 32'd3);
        run_txn(1'b0, 4'b0000, 32'h500, 32'h0, LT_LW, 1, 32'h89ABCDEF);
        chk("lw_rdata", cap_rdata, 32'h89ABCDEF);

        // Ignored ops: store with no byte enables, load with no type.
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_we = 1'b1; mif.byteen = 4'b0000; mif.addr = 32'h800;
        @(negedge clk);
        chk("ign_st_stall", {31'b0, mif.stall}, 32'd0);
        @(negedge clk);
        chk("ign_st_req", {31'b0, mif.bus_req}, 32'd0);
        mif.req_we = 1'b0; mif.load_type = LT_NONE;
        @(negedge clk);
        chk("ign_ld_stall", {31'b0, mif.stall}, 32'd0);
        @(negedge clk);
        chk("ign_ld_req", {31'b0, mif.bus_req}, 32'd0);
        mif.req_valid = 1'b0;

        run_txn(1'b1, 4'b0011, 32'h900, 32'h00001234, LT_NONE, 1, 32'h0);
        chk("st_rdata_hold", cap_rdata, 32'h89ABCDEF);
        chk("sh_wdata", cap_wdata, 32'h00001234);

        run_txn(1'b0, 4'b0000, 32'h600, 32'h0, LT_LW, 0, 32'h55555555);
        chk("to_req_cyc", req_cyc, 32'd16);
        chk("to_err", err_cnt, 32'd1);
        chk("to_vld", vld_cnt, 32'd0);
        chk("to_stall", stall_cyc, 32'd17);
        chk("to_rdata", cap_rdata, 32'd0);

        // Reset in the second REQ cycle.
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_we = 1'b1; mif.byteen = 4'b1111;
        mif.addr = 32'h700; mif.wdata = 32'h11223344; mif.bus_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_req_pre", {31'b0, mif.bus_req}, 32'd1);
        rst = 1'b1; mif.req_valid = 1'b0;
        #1;
        chk("rst_mid_req", {31'b0, mif.bus_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, mif.stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(1'b1, 4'b1111, 32'h704, 32'hCAFEF00D, LT_NONE, 2, 32'h0);
        chk("post_rst_addr", cap_addr, 32'h704);
        chk("post_rst_wdata", cap_wdata, 32'hCAFEF00D);
        chk("post_rst_stall", stall_cyc, 32'd3);

`ifdef MEM_ALIGN_CHECK_EN
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.load_type = LT_LW; mif.addr = 32'h101;
        @(negedge clk);
        chk("al_lw_exc", {31'b0, mif.align_exc}, 32'd1);
        chk("al_lw_stall", {31'b0, mif.stall}, 32'd0);
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        @(negedge clk);
        chk("al_lw_exc_off", {31'b0, mif.align_exc}, 32'd0);
        chk("al_lw_req", {31'b0, mif.bus_req}, 32'd0);
        @(posedge clk); #1;
        mif.req_valid = 1'b1; mif.req_we = 1'b1; mif.byteen = 4'b0011; mif.addr = 32'h201;
        @(negedge clk);
        chk("al_sh_exc", {31'b0, mif.align_exc}, 32'd1);
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        @(negedge clk);
        chk("al_sh_req", {31'b0, mif.bus_req}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
